// File: rtl/fx_requant_pkg.sv
// Shared widths and saturation constants for the requantizer.
// Default format: Q7.10 (18b) in, Q6.6 (13b) out.
package fx_requant_pkg;

  localparam int IN_W_D     = 18;
  localparam int IN_FRAC_D  = 10;
  localparam int OUT_W_D    = 13;
  localparam int OUT_FRAC_D = 6;
  localparam int CNT_W_D    = 16;

  localparam int SH    = IN_FRAC_D - OUT_FRAC_D;
  localparam int RND_W = IN_W_D - SH + 1;

  localparam logic [OUT_W_D-1:0] SAT_MAX =
    {1'b0, {(OUT_W_D-1){1'b1}}};
  localparam logic [OUT_W_D-1:0] SAT_MIN =
    {1'b1, {(OUT_W_D-1){1'b0}}};

endpackage

// File: rtl/fx_sat_event_cnt.sv
// Saturating event counter with sticky flag.
// Ports: clk, rst_n, clr (sync, wins), hit, sticky, cnt.
module fx_sat_event_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             hit,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  logic full;

  assign full = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (clr) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (hit) begin
      sticky <= 1'b1;
      if (!full)
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fx_requant_pipe.sv
// Two-stage round-half-up + saturate requantizer, valid/ready both sides.
// Ports: i_data/i_valid/o_ready in, o_data/o_sat/o_valid/i_ready out, sat stats.
module fx_requant_pipe
  import fx_requant_pkg::*;
#(
  parameter int IN_W     = IN_W_D,
  parameter int IN_FRAC  = IN_FRAC_D,
  parameter int OUT_W    = OUT_W_D,
  parameter int OUT_FRAC = OUT_FRAC_D,
  parameter int CNT_W    = CNT_W_D
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sat,
  output logic             o_ovf_sticky,
  output logic [CNT_W-1:0] o_sat_cnt,
  input  logic             i_clr
);

  localparam int SHF = IN_FRAC - OUT_FRAC;
  localparam int RW  = IN_W - SHF + 1;

  localparam logic [IN_W:0] HALF =
    (IN_W+1)'(1) << (SHF-1);

  localparam logic [RW-1:0] MAXV =
    {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [RW-1:0] MINV =
    {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  localparam logic [OUT_W-1:0] OMAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OMIN =
    {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W:0]    ext;
  logic [RW-1:0]    rnd;
  logic             s1_valid;
  logic [RW-1:0]    s1_data;
  logic             hi;
  logic             lo;
  logic [OUT_W-1:0] sat_data;
  logic             s2_ready;
  logic             s1_open;
  logic             in_xfer;
  logic             rdy_en;
  logic             sat_hit;

  // One guard bit absorbs the rounding carry; the
  // top RW bits of the sum are the shifted result.
  assign ext = {i_data[IN_W-1], i_data} + HALF;
  assign rnd = RW'(ext >> SHF);

  assign hi = $signed(s1_data) > $signed(MAXV);
  assign lo = $signed(s1_data) < $signed(MINV);

  always_comb begin
    sat_data = s1_data[OUT_W-1:0];
    unique case (1'b1)
      hi:      sat_data = OMAX;
      lo:      sat_data = OMIN;
      default: sat_data = s1_data[OUT_W-1:0];
    endcase
  end

  assign s2_ready = !o_valid || i_ready;
  assign s1_open  = !s1_valid || s2_ready;

  // rdy_en keeps o_ready low until the first edge
  // after reset is released.
  assign o_ready = rdy_en && s1_open;
  assign in_xfer = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdy_en   <= 1'b0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_sat    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (s1_open) begin
        s1_valid <= in_xfer;
        if (in_xfer)
          s1_data <= rnd;
      end
      if (s2_ready) begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_data <= sat_data;
          o_sat  <= hi || lo;
        end
      end
    end
  end

  assign sat_hit = o_valid && i_ready && o_sat;

  fx_sat_event_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clr    (i_clr),
    .hit    (sat_hit),
    .sticky (o_ovf_sticky),
    .cnt    (o_sat_cnt)
  );

endmodule

// File: tb/tb_fx_requant_pipe.sv
// Directed self-checking bench for fx_requant_pipe.
// Second instance with CNT_W=4 shares all inputs.
module tb_fx_requant_pipe;

  logic        clk;
  logic        rst_n;
  logic [17:0] i_data;
  logic        i_valid;
  logic        i_ready;
  logic        i_clr;
  logic        o_ready;
  logic [12:0] o_data;
  logic        o_valid;
  logic        o_sat;
  logic        o_ovf_sticky;
  logic [15:0] o_sat_cnt;

  logic        r4;
  logic [12:0] d4;
  logic        v4;
  logic        s4;
  logic        st4;
  logic [3:0]  c4;

  int vec;
  int miscmp;

  fx_requant_pipe dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_sat        (o_sat),
    .o_ovf_sticky (o_ovf_sticky),
    .o_sat_cnt    (o_sat_cnt),
    .i_clr        (i_clr)
  );

  fx_requant_pipe #(.CNT_W(4)) dut4 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (r4),
    .o_data       (d4),
    .o_valid      (v4),
    .i_ready      (i_ready),
    .o_sat        (s4),
    .o_ovf_sticky (st4),
    .o_sat_cnt    (c4),
    .i_clr        (i_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vec++;
    if (o_valid !== 1'b0) begin
      miscmp++;
      $display("FAIL rst_valid: got %b want 0", o_valid);
    end
    vec++;
    if (o_ready !== 1'b0) begin
      miscmp++;
      $display("FAIL rst_ready: got %b want 0", o_ready);
    end
    vec++;
    if (o_data !== 13'h0 || o_sat !== 1'b0) begin
      miscmp++;
      $display("FAIL rst_data: got %h/%b want 0/0",
               o_data, o_sat);
    end
    vec++;
    if (o_sat_cnt !== 16'h0 || o_ovf_sticky !== 1'b0) begin
      miscmp++;
      $display("FAIL rst_cnt: got %h/%b want 0/0",
               o_sat_cnt, o_ovf_sticky);
    end
    tick();
    tick();
    vec++;
    if (o_ready !== 1'b0) begin
      miscmp++;
      $display("FAIL rst_hold_ready: got %b want 0", o_ready);
    end
    rst_n = 1'b1;
    #1;
    vec++;
    if (o_ready !== 1'b0) begin
      miscmp++;
      $display("FAIL rel_ready: got %b want 0", o_ready);
    end
    tick();
    vec++;
    if (o_ready !== 1'b1) begin
      miscmp++;
      $display("FAIL post_rel_ready: got %b want 1", o_ready);
    end
  endtask

  task automatic test_round();
    i_ready = 1'b1;
    i_data  = 18'h00018;
    i_valid = 1'b1;
    tick();
    vec++;
    if (o_valid !== 1'b0) begin
      miscmp++;
      $display("FAIL rnd_lat: got valid %b want 0", o_valid);
    end
    i_data = 18'h3FFE8;
    tick();
    i_valid = 1'b0;
    vec++;
    if (o_valid !== 1'b1 || o_data !== 13'h0002 || o_sat !== 1'b0) begin
      miscmp++;
      $display("FAIL rnd_pos: got %b/%h/%b want 1/0002/0",
               o_valid, o_data, o_sat);
    end
    tick();
    vec++;
    if (o_valid !== 1'b1 || o_data !== 13'h1FFF || o_sat !== 1'b0) begin
      miscmp++;
      $display("FAIL rnd_neg: got %b/%h/%b want 1/1fff/0",
               o_valid, o_data, o_sat);
    end
    tick();
    vec++;
    if (o_valid !== 1'b0) begin
      miscmp++;
      $display("FAIL rnd_drain: got valid %b want 0", o_valid);
    end
  endtask

  task automatic test_sat();
    i_data  = 18'h1FFFF;
    i_valid = 1'b1;
    tick();
    i_data = 18'h20000;
    tick();
    i_valid = 1'b0;
    vec++;
    if (o_valid !== 1'b1 || o_data !== 13'h0FFF || o_sat !== 1'b1) begin
      miscmp++;
      $display("FAIL sat_pos: got %b/%h/%b want 1/0fff/1",
               o_valid, o_data, o_sat);
    end
    tick();
    vec++;
    if (o_data !== 13'h1000 || o_sat !== 1'b1 || o_sat_cnt !== 16'd1) begin
      miscmp++;
      $display("FAIL sat_neg: got %h/%b/%0d want 1000/1/1",
               o_data, o_sat, o_sat_cnt);
    end
    tick();
    vec++;
    if (o_sat_cnt !== 16'd2 || o_ovf_sticky !== 1'b1) begin
      miscmp++;
      $display("FAIL sat_cnt: got %0d/%b want 2/1",
               o_sat_cnt, o_ovf_sticky);
    end
  endtask

  task automatic test_stall();
    i_ready = 1'b0;
    i_data  = 18'h00100;
    i_valid = 1'b1;
    #1;
    vec++;
    if (o_ready !== 1'b1) begin
      miscmp++;
      $display("FAIL stall_rdy0: got %b want 1", o_ready);
    end
    tick();
    i_data = 18'h3FF00;
    #1;
    vec++;
    if (o_ready !== 1'b1) begin
      miscmp++;
      $display("FAIL stall_rdy1: got %b want 1", o_ready);
    end
    tick();
    i_data = 18'h00058;
    #1;
    for (int k = 0; k < 5; k++) begin
      vec++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 13'h0010) begin
        miscmp++;
        $display("FAIL stall_hold%0d: got %b/%b/%h want 0/1/0010",
                 k, o_ready, o_valid, o_data);
      end
      tick();
    end
    i_ready = 1'b1;
    #1;
    vec++;
    if (o_ready !== 1'b1) begin
      miscmp++;
      $display("FAIL stall_resume: got %b want 1", o_ready);
    end
    tick();
    i_valid = 1'b0;
    vec++;
    if (o_valid !== 1'b1 || o_data !== 13'h1FF0) begin
      miscmp++;
      $display("FAIL stall_b: got %b/%h want 1/1ff0", o_valid, o_data);
    end
    tick();
    vec++;
    if (o_valid !== 1'b1 || o_data !== 13'h0006) begin
      miscmp++;
      $display("FAIL stall_c: got %b/%h want 1/0006", o_valid, o_data);
    end
    tick();
    vec++;
    if (o_valid !== 1'b0) begin
      miscmp++;
      $display("FAIL stall_drain: got %b want 0", o_valid);
    end
  endtask

  task automatic test_clr();
    i_data  = 18'h1FFFF;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    vec++;
    if (o_valid !== 1'b1 || o_sat !== 1'b1 || o_sat_cnt !== 16'd2) begin
      miscmp++;
      $display("FAIL clr_pre: got %b/%b/%0d want 1/1/2",
               o_valid, o_sat, o_sat_cnt);
    end
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    vec++;
    if (o_sat_cnt !== 16'd0 || o_ovf_sticky !== 1'b0) begin
      miscmp++;
      $display("FAIL clr_cnt: got %0d/%b want 0/0",
               o_sat_cnt, o_ovf_sticky);
    end
    vec++;
    if (o_valid !== 1'b0 || c4 !== 4'h0) begin
      miscmp++;
      $display("FAIL clr_pipe: got %b/%h want 0/0", o_valid, c4);
    end
  endtask

  task automatic test_cnt_sat();
    i_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      i_data  = (i % 2 == 1) ? 18'h20000 : 18'h1FFFF;
      i_valid = 1'b1;
      #1;
      vec++;
      if (o_ready !== 1'b1) begin
        miscmp++;
        $display("FAIL tput%0d: got ready %b want 1", i, o_ready);
      end
      tick();
    end
    i_valid = 1'b0;
    tick();
    tick();
    vec++;
    if (c4 !== 4'hF || st4 !== 1'b1) begin
      miscmp++;
      $display("FAIL cnt4_hold: got %h/%b want f/1", c4, st4);
    end
    vec++;
    if (o_sat_cnt !== 16'd20) begin
      miscmp++;
      $display("FAIL cnt16: got %0d want 20", o_sat_cnt);
    end
    vec++;
    if (v4 !== 1'b0 || d4 !== 13'h1000 || s4 !== 1'b1 || r4 !== 1'b1) begin
      miscmp++;
      $display("FAIL cnt4_pipe: got %b/%h/%b/%b want 0/1000/1/1",
               v4, d4, s4, r4);
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    i_data  = 18'h00018;
    i_valid = 1'b1;
    tick();
    tick();
    i_valid = 1'b0;
    vec++;
    if (o_valid !== 1'b1) begin
      miscmp++;
      $display("FAIL mid_pre: got valid %b want 1", o_valid);
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_data !== 13'h0) begin
      miscmp++;
      $display("FAIL mid_rst: got %b/%b/%h want 0/0/0",
               o_valid, o_ready, o_data);
    end
    vec++;
    if (o_sat_cnt !== 16'd0 || o_ovf_sticky !== 1'b0) begin
      miscmp++;
      $display("FAIL mid_cnt: got %0d/%b want 0/0",
               o_sat_cnt, o_ovf_sticky);
    end
    tick();
    rst_n   = 1'b1;
    i_ready = 1'b1;
    tick();
    vec++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      miscmp++;
      $display("FAIL mid_rel: got %b/%b want 0/1", o_valid, o_ready);
    end
    i_data  = 18'h00058;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    vec++;
    if (o_valid !== 1'b0) begin
      miscmp++;
      $display("FAIL mid_stale: got valid %b want 0", o_valid);
    end
    tick();
    vec++;
    if (o_valid !== 1'b1 || o_data !== 13'h0006) begin
      miscmp++;
      $display("FAIL mid_first: got %b/%h want 1/0006", o_valid, o_data);
    end
    tick();
    vec++;
    if (o_valid !== 1'b0) begin
      miscmp++;
      $display("FAIL mid_drain: got %b want 0", o_valid);
    end
  endtask

  initial begin
    vec     = 0;
    miscmp  = 0;
    clk     = 1'b0;
    rst_n   = 1'b0;
    i_data  = '0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_clr   = 1'b0;
    test_reset();
    test_round();
    test_sat();
    test_stall();
    test_clr();
    test_cnt_sat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule

// File: doc/fx_requant_pipe.md
FX_REQUANT_PIPE -- requirements
Module: fx_requant_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 18, input word width (signed, two's complement).
REQ-002 SHALL have parameter IN_FRAC, default 10, input fractional bits.
REQ-003 SHALL have parameter OUT_W, default 13, output word width (signed).
REQ-004 SHALL have parameter OUT_FRAC, default 6, output fractional bits; IN_FRAC > OUT_FRAC and IN_W > OUT_W are required.
REQ-005 SHALL have parameter CNT_W, default 16, saturation counter width.
REQ-006 i_clk  input  1  single clock; all logic on rising edge.
REQ-007 i_rst_n  input  1  asynchronous, active-low reset.
REQ-008 i_data  input  IN_W  signed sample to requantize.
REQ-009 i_valid  input  1  i_data valid.
REQ-010 o_ready  output  1  block accepts i_data this cycle.
REQ-011 o_data  output  OUT_W  requantized signed sample; feeds the 13-bit format-match/delay stage.
REQ-012 o_valid  output  1  o_data valid.
REQ-013 i_ready  input  1  downstream accepts o_data.
REQ-014 o_sat  output  1  current o_data was saturated (qualified by o_valid).
REQ-015 o_ovf_sticky  output  1  set on any saturated output transfer; held until cleared.
REQ-016 o_sat_cnt  output  CNT_W  count of saturated output transfers, saturating at all-ones.
REQ-017 i_clr  input  1  synchronous clear of o_ovf_sticky and o_sat_cnt.

Function
REQ-018 Input transfer SHALL occur when i_valid and o_ready are both high at a rising edge; output transfer when o_valid and i_ready are both high.
REQ-019 Stage 1 SHALL round: add 2^(SH-1) to sign-extended i_data (SH = IN_FRAC-OUT_FRAC = 4), arithmetic-shift right by SH; result width IN_W-SH+1, no overflow possible.
REQ-020 Rounding SHALL be round-half-up (ties toward +inf): +1.5 LSB -> +2, -1.5 LSB -> -1.
REQ-021 Stage 2 SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and register o_data and o_sat alongside.
REQ-022 Latency SHALL be exactly 2 cycles with no stall: input accepted at edge N, o_valid high after edge N+2.
REQ-023 Each stage SHALL load when empty or when its contents move on the same edge (bubble collapsing); o_ready = !s1_valid || s1 advances this cycle.
REQ-024 o_ready SHALL not depend combinationally on i_valid; it may depend on i_ready.
REQ-025 Under i_ready low, o_data/o_sat/o_valid SHALL hold stable; no sample lost, duplicated or reordered; the pipeline holds at most 2 samples.
REQ-026 Throughput SHALL be one sample per cycle while i_valid and i_ready are continuously high.
REQ-027 o_sat_cnt SHALL increment on each output transfer with o_sat high, and hold at 2^CNT_W-1.
REQ-028 i_clr SHALL take precedence over a simultaneous saturated transfer: counter -> 0, sticky -> 0, that event is not counted.
REQ-029 i_clr SHALL not affect pipeline data or handshake.

Reset
REQ-030 While i_rst_n is low: both stage valids, o_valid, o_sat, o_ovf_sticky = 0, o_sat_cnt = 0, o_data = 0; o_ready = 1 only after the reset release edge.
REQ-031 Reset mid-operation SHALL discard in-flight samples; first post-reset output is the first sample accepted after release.

Structure
REQ-032 Package fx_requant_pkg SHALL hold the default widths, SH, and min/max saturation constants.
REQ-033 The saturating event counter plus sticky flag SHALL be one sub-module, fx_sat_event_cnt.
REQ-034 Implementation SHALL be 120-400 lines, with no vendor primitives.

Verification
REQ-035 i_ready=1; inputs 0x00018, 0x3FFE8 (+24, -24) -> o_data 0x0002, 0x1FFF (+2, -1) two cycles later, o_sat=0.
REQ-036 Inputs 0x1FFFF, 0x20000 -> o_data 0x0FFF, 0x1000, o_sat=1 each; o_sat_cnt=2, o_ovf_sticky=1.
REQ-037 Stream 3 samples, i_ready=0 for 5 cycles -> o_ready low after 2 accepted; after i_ready=1 all 3 emerge in order unchanged.
REQ-038 i_clr asserted in same cycle as a saturated output transfer -> o_sat_cnt=0, o_ovf_sticky=0 next cycle.
REQ-039 CNT_W=4, 20 saturated transfers -> o_sat_cnt holds 0xF.
REQ-040 i_rst_n pulsed low with 2 samples in flight -> o_valid=0 immediately; no stale output after release.
